// File: rtl/video_dvi_encoder_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder.
// DVI_OUTPUT_REG_EN selects the 3-clock latency variant.
package video_dvi_encoder_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

`ifdef DVI_OUTPUT_REG_EN
  localparam int unsigned DVI_LATENCY = 3;
`else
  localparam int unsigned DVI_LATENCY = 2;
`endif

  function automatic logic [9:0] tmds_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    case (ctrl)
      2'b01:   tok = TMDS_CTRL_01;
      2'b10:   tok = TMDS_CTRL_10;
      2'b11:   tok = TMDS_CTRL_11;
      default: tok = TMDS_CTRL_00;
    endcase
    return tok;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/video_dvi_encoder_tmds_channel_encoder.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage with running disparity.
// Emits the control token selected by ctrl_i whenever the stage-2 pixel is blanking.
module video_dvi_encoder_tmds_channel_encoder
  import video_dvi_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic [7:0] data_i,
  input  logic       visible_i,
  input  logic [1:0] ctrl_i,
  output logic [9:0] symbol_o
);

  logic [3:0] n1_data;
  logic       use_xnor;
  logic [8:0] q_m_d;

  logic [8:0] q_m_q;
  logic [3:0] n1q_q;
  logic       visible_q;
  logic [1:0] ctrl_q;

  logic signed [5:0] diff;
  logic signed [5:0] delta;
  logic signed [5:0] sum;
  logic signed [4:0] cnt_q, cnt_d;
  logic [9:0]        symbol_d, symbol_q;

  always_comb begin
    n1_data  = popcount8(data_i);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);
    q_m_d    = '0;
    q_m_d[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_i[i]) : (q_m_d[i-1] ^ data_i[i]);
    end
    q_m_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q_m_q     <= '0;
      n1q_q     <= '0;
      visible_q <= 1'b0;
      ctrl_q    <= 2'b00;
    end else begin
      q_m_q     <= q_m_d;
      n1q_q     <= popcount8(q_m_d[7:0]);
      visible_q <= visible_i;
      ctrl_q    <= ctrl_i;
    end
  end

  // diff = ones - zeros of the 8 payload bits
  always_comb begin
    diff     = $signed({1'b0, n1q_q, 1'b0}) - 6'sd8;
    delta    = '0;
    sum      = '0;
    cnt_d    = '0;
    symbol_d = tmds_token(ctrl_q);
    if (visible_q) begin
      if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
        symbol_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
        delta    = q_m_q[8] ? diff : -diff;
      end else if (((cnt_q > 5'sd0) && (diff > 6'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 6'sd0))) begin
        symbol_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
        delta    = (q_m_q[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        symbol_d = {1'b0, q_m_q[8], q_m_q[7:0]};
        delta    = diff - (q_m_q[8] ? 6'sd0 : 6'sd2);
      end
      sum   = {cnt_q[4], cnt_q} + delta;
      cnt_d = sum[4:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      symbol_q <= TMDS_CTRL_00;
    end else begin
      cnt_q    <= cnt_d;
      symbol_q <= symbol_d;
    end
  end

  assign symbol_o = symbol_q;

endmodule

// File: rtl/video_dvi_encoder.sv
// DVI 1.0 TMDS encoder: expands RGB to 8 bits, routes sync to blue, aligns visible_o.
// Define DVI_OUTPUT_REG_EN to add an output register stage (latency 3 instead of 2).
module video_dvi_encoder
  import video_dvi_encoder_pkg::*;
#(
  parameter int unsigned COLOR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [COLOR_BITS-1:0] red_i,
  input  logic [COLOR_BITS-1:0] green_i,
  input  logic [COLOR_BITS-1:0] blue_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic                  visible_i,
  output logic [9:0]            tmds_r_o,
  output logic [9:0]            tmds_g_o,
  output logic [9:0]            tmds_b_o,
  output logic                  visible_o
);

  localparam int unsigned Reps   = (8 + COLOR_BITS - 1) / COLOR_BITS;
  localparam int unsigned RepW   = Reps * COLOR_BITS;

  logic [RepW-1:0] red_rep, green_rep, blue_rep;
  logic [7:0]      red8, green8, blue8;
  logic [9:0]      sym_r, sym_g, sym_b;

  // Replicate the colour MSB-first so full scale maps to 8'hFF
  assign red_rep   = {Reps{red_i}};
  assign green_rep = {Reps{green_i}};
  assign blue_rep  = {Reps{blue_i}};
  assign red8      = red_rep[RepW-1 -: 8];
  assign green8    = green_rep[RepW-1 -: 8];
  assign blue8     = blue_rep[RepW-1 -: 8];

  video_dvi_encoder_tmds_channel_encoder u_enc_r (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .data_i    (red8),
    .visible_i (visible_i),
    .ctrl_i    (2'b00),
    .symbol_o  (sym_r)
  );

  video_dvi_encoder_tmds_channel_encoder u_enc_g (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .data_i    (green8),
    .visible_i (visible_i),
    .ctrl_i    (2'b00),
    .symbol_o  (sym_g)
  );

  video_dvi_encoder_tmds_channel_encoder u_enc_b (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .data_i    (blue8),
    .visible_i (visible_i),
    .ctrl_i    ({vsync_i, hsync_i}),
    .symbol_o  (sym_b)
  );

  logic [DVI_LATENCY-1:0] vis_pipe_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vis_pipe_q <= '0;
    end else begin
      vis_pipe_q <= {vis_pipe_q[DVI_LATENCY-2:0], visible_i};
    end
  end

  assign visible_o = vis_pipe_q[DVI_LATENCY-1];

`ifdef DVI_OUTPUT_REG_EN
  logic [9:0] tmds_r_q, tmds_g_q, tmds_b_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmds_r_q <= TMDS_CTRL_00;
      tmds_g_q <= TMDS_CTRL_00;
      tmds_b_q <= TMDS_CTRL_00;
    end else begin
      tmds_r_q <= sym_r;
      tmds_g_q <= sym_g;
      tmds_b_q <= sym_b;
    end
  end

  assign tmds_r_o = tmds_r_q;
  assign tmds_g_o = tmds_g_q;
  assign tmds_b_o = tmds_b_q;
`else
  assign tmds_r_o = sym_r;
  assign tmds_g_o = sym_g;
  assign tmds_b_o = sym_b;
`endif

endmodule

// File: tb/tb_video_dvi_encoder.sv
// Self-checking bench for video_dvi_encoder against a symbol-level TMDS reference model.
module tb_video_dvi_encoder;

`ifdef DVI_OUTPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic       hsync = 1'b0, vsync = 1'b0, visible = 1'b0;
  logic [9:0] tmds_r, tmds_g, tmds_b;
  logic       visible_o;

  video_dvi_encoder #(.COLOR_BITS(4)) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .red_i     (red),
    .green_i   (green),
    .blue_i    (blue),
    .hsync_i   (hsync),
    .vsync_i   (vsync),
    .visible_i (visible),
    .tmds_r_o  (tmds_r),
    .tmds_g_o  (tmds_g),
    .tmds_b_o  (tmds_b),
    .visible_o (visible_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] r, g, b;
    logic       vis;
    logic [7:0] dr, dg, db;
    int         tag;
  } ent_t;

  int   total = 0;
  int   bad = 0;
  ent_t expq[$];
  int   mcnt[3];
  int   push_cnt = 0;

  function automatic int ones(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  // Reference: pick the q_m form, decide inversion, and track disparity as the
  // accumulated (ones - zeros) of the symbols actually emitted.
  function automatic logic [9:0] model_sym(input logic [7:0] d, input logic vis,
                                           input logic [1:0] ctrl, inout int cnt);
    logic [7:0] qm;
    logic       q8, inv;
    int         n1, diff;
    logic [9:0] s;
    if (!vis) begin
      cnt = 0;
      case (ctrl)
        2'b00:   s = 10'h354;
        2'b01:   s = 10'h0AB;
        2'b10:   s = 10'h154;
        default: s = 10'h2AB;
      endcase
      return s;
    end
    n1 = ones({2'b00, d});
    q8 = !((n1 > 4) || (n1 == 4 && d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = q8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    diff = 2 * ones({2'b00, qm}) - 8;
    if (cnt == 0 || diff == 0) inv = !q8;
    else inv = ((cnt > 0) == (diff > 0));
    s = {inv, q8, inv ? ~qm : qm};
    cnt += 2 * ones(s) - 10;
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Pipeline right after reset holds only blanking/ctrl 00 contents.
  task automatic reset_model();
    ent_t z;
    expq.delete();
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    z = '0;
    z.r = 10'h354; z.g = 10'h354; z.b = 10'h354; z.vis = 1'b0; z.tag = -1;
    for (int i = 0; i < LAT; i++) expq.push_back(z);
  endtask

  task automatic cycle(input logic [3:0] r, g, b, input logic hs, vs, vis,
                       output ent_t e, output ent_t o, output bit have);
    ent_t n;
    @(negedge clk);
    have = 1'b0;
    e = '0;
    o = '0;
    if (expq.size() >= LAT) begin
      e = expq.pop_front();
      o = e;
      o.r = tmds_r; o.g = tmds_g; o.b = tmds_b; o.vis = visible_o;
      have = 1'b1;
    end
    red = r; green = g; blue = b; hsync = hs; vsync = vs; visible = vis;
    n = '0;
    n.dr = {r, r}; n.dg = {g, g}; n.db = {b, b};
    n.r = model_sym(n.dr, vis, 2'b00, mcnt[0]);
    n.g = model_sym(n.dg, vis, 2'b00, mcnt[1]);
    n.b = model_sym(n.db, vis, {vs, hs}, mcnt[2]);
    n.vis = vis;
    n.tag = push_cnt;
    push_cnt++;
    expq.push_back(n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (tmds_r !== 10'h354) begin bad++; $display("FAIL reset_r got=%h want=354", tmds_r); end
    if (tmds_g !== 10'h354) begin bad++; $display("FAIL reset_g got=%h want=354", tmds_g); end
    if (tmds_b !== 10'h354) begin bad++; $display("FAIL reset_b got=%h want=354", tmds_b); end
    if (visible_o !== 1'b0) begin bad++; $display("FAIL reset_vis got=%b want=0", visible_o); end
    reset_n = 1'b1;
    reset_model();
  endtask

  task automatic test_blank_sync();
    ent_t e, o;
    bit   have;
    int   base;
    base = push_cnt;
    for (int i = 0; i < 8 + LAT; i++) begin
      if (i < 8) cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0, e, o, have);
      else cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                 e, o, have);
      if (have) begin
        total++;
        if ({o.r, o.g, o.b, o.vis} !== {e.r, e.g, e.b, e.vis}) begin
          bad++;
          $display("FAIL blank_model tag=%0d got %h %h %h %b want %h %h %h %b", e.tag,
                   o.r, o.g, o.b, o.vis, e.r, e.g, e.b, e.vis);
        end
        if (e.tag >= base && e.tag < base + 8) begin
          total++;
          if ({o.r, o.g, o.b} !== {10'h354, 10'h354, 10'h0AB}) begin
            bad++;
            $display("FAIL blank_hsync tag=%0d got r=%h g=%h b=%h want r=354 g=354 b=0ab",
                     e.tag, o.r, o.g, o.b);
          end
        end
      end
    end
  endtask

  task automatic test_black();
    ent_t       e, o;
    bit         have;
    int         base;
    logic [9:0] seq[4];
    seq = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    repeat (LAT) cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, e, o, have);
    base = push_cnt;
    for (int i = 0; i < 4 + LAT; i++) begin
      cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, i < 4, e, o, have);
      if (have && e.tag >= base && e.tag < base + 4) begin
        total++;
        if ({o.r, o.g, o.b} !== {3{seq[e.tag-base]}}) begin
          bad++;
          $display("FAIL black_run idx=%0d got %h %h %h want %h", e.tag - base,
                   o.r, o.g, o.b, seq[e.tag-base]);
        end
      end
    end
  endtask

  task automatic test_white();
    ent_t e, o;
    bit   have;
    int   base;
    repeat (LAT) cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, e, o, have);
    base = push_cnt;
    for (int i = 0; i < 2 + LAT; i++) begin
      if (i == 0) cycle(4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, e, o, have);
      else cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, i == 1, e, o, have);
      if (have && e.tag == base) begin
        total++;
        if ({o.r, o.g, o.b} !== {3{10'h200}}) begin
          bad++;
          $display("FAIL white_first got %h %h %h want 200", o.r, o.g, o.b);
        end
      end
      // After white cnt=-8, so a black pixel must come out inverted
      if (have && e.tag == base + 1) begin
        total++;
        if ({o.r, o.g, o.b} !== {3{10'h3FF}}) begin
          bad++;
          $display("FAIL white_then_black got %h %h %h want 3ff", o.r, o.g, o.b);
        end
      end
    end
  endtask

  task automatic test_random();
    ent_t       e, o;
    bit         have;
    logic       vis_cur;
    int         rd[3];
    logic [9:0] s;
    vis_cur = 1'b1;
    for (int c = 0; c < 3; c++) rd[c] = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 31) == 0) vis_cur = ~vis_cur;
      cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), vis_cur,
            e, o, have);
      if (!have) continue;
      total++;
      if ({o.r, o.g, o.b, o.vis} !== {e.r, e.g, e.b, e.vis}) begin
        bad++;
        $display("FAIL rand_model tag=%0d got %h %h %h %b want %h %h %h %b", e.tag,
                 o.r, o.g, o.b, o.vis, e.r, e.g, e.b, e.vis);
      end
      if (e.vis) begin
        total++;
        if ({decode(o.r), decode(o.g), decode(o.b)} !== {e.dr, e.dg, e.db}) begin
          bad++;
          $display("FAIL rand_decode tag=%0d got %h %h %h want %h %h %h", e.tag,
                   decode(o.r), decode(o.g), decode(o.b), e.dr, e.dg, e.db);
        end
        for (int c = 0; c < 3; c++) begin
          s = (c == 0) ? o.r : (c == 1) ? o.g : o.b;
          rd[c] += 2 * ones(s) - 10;
        end
        total++;
        if (rd[0] > 10 || rd[0] < -10 || rd[1] > 10 || rd[1] < -10 ||
            rd[2] > 10 || rd[2] < -10) begin
          bad++;
          $display("FAIL rand_disparity tag=%0d got %0d %0d %0d want within +/-10", e.tag,
                   rd[0], rd[1], rd[2]);
        end
      end else begin
        for (int c = 0; c < 3; c++) rd[c] = 0;
      end
    end
  endtask

  task automatic test_visible_toggle();
    ent_t       e, o;
    bit         have;
    logic [3:0] pr, pg, pb;
    logic       vseq[13];
    int         base, c0;
    logic [9:0] fresh_r, fresh_g, fresh_b;
    vseq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pr = 4'($urandom); pg = 4'($urandom); pb = 4'($urandom);
    c0 = 0; fresh_r = model_sym({pr, pr}, 1'b1, 2'b00, c0);
    c0 = 0; fresh_g = model_sym({pg, pg}, 1'b1, 2'b00, c0);
    c0 = 0; fresh_b = model_sym({pb, pb}, 1'b1, 2'b00, c0);
    base = push_cnt;
    for (int i = 0; i < 13; i++) begin
      cycle(pr, pg, pb, 1'($urandom), 1'($urandom), vseq[i], e, o, have);
      if (!have) continue;
      total++;
      if ({o.r, o.g, o.b, o.vis} !== {e.r, e.g, e.b, e.vis}) begin
        bad++;
        $display("FAIL toggle_model tag=%0d got %h %h %h %b want %h %h %h %b", e.tag,
                 o.r, o.g, o.b, o.vis, e.r, e.g, e.b, e.vis);
      end
      if (i >= LAT) begin
        total++;
        if (o.vis !== vseq[i-LAT]) begin
          bad++;
          $display("FAIL toggle_vis_lag i=%0d got %b want %b", i, o.vis, vseq[i-LAT]);
        end
      end
      if (e.tag == base + 2 || e.tag == base + 9) begin
        total++;
        if ({o.r, o.g, o.b} !== {fresh_r, fresh_g, fresh_b}) begin
          bad++;
          $display("FAIL toggle_fresh tag=%0d got %h %h %h want %h %h %h", e.tag,
                   o.r, o.g, o.b, fresh_r, fresh_g, fresh_b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e, o;
    bit   have;
    for (int i = 0; i < 6; i++) begin
      cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b1, e, o, have);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total += 4;
    if (tmds_r !== 10'h354) begin bad++; $display("FAIL midrst_r got=%h want=354", tmds_r); end
    if (tmds_g !== 10'h354) begin bad++; $display("FAIL midrst_g got=%h want=354", tmds_g); end
    if (tmds_b !== 10'h354) begin bad++; $display("FAIL midrst_b got=%h want=354", tmds_b); end
    if (visible_o !== 1'b0) begin bad++; $display("FAIL midrst_vis got=%b want=0", visible_o); end
    red = '0; green = '0; blue = '0; hsync = 1'b0; vsync = 1'b0; visible = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    for (int i = 0; i < 12; i++) begin
      cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), i > 2,
            e, o, have);
      if (have) begin
        total++;
        if ({o.r, o.g, o.b, o.vis} !== {e.r, e.g, e.b, e.vis}) begin
          bad++;
          $display("FAIL midrst_recover tag=%0d got %h %h %h %b want %h %h %h %b", e.tag,
                   o.r, o.g, o.b, o.vis, e.r, e.g, e.b, e.vis);
        end
      end
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    test_reset();
    test_blank_sync();
    test_black();
    test_white();
    test_visible_toggle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
